reg_file_bank: RTL

//   Parametrised general-purpose register file for the datapath; successor to the 4x8 file.
//   Two combinational read ports, two write ports with fixed priority, optional write-through bypass,

---
 rtl/reg_file_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reg_file_bank.sv
// -----------------------------------------------------------------------------
// reg_file_bank
//   Parametrised general-purpose register file for the datapath.
//   DEPTH = 2**ADDR_W registers of DATA_W bits each.
//   - Two combinational read ports, with optional write-through bypass (BYPASS).
//   - Two write ports. Port 1 wins when both ports target the same address.
//   - Optional hardwired zero register 0 (ZERO_REG).
//   - Soft-clear sweep that zeroes one register per cycle, with busy/done status.
//
// Ports
//   clk                       clock, all state updates on the rising edge
//   reset                     asynchronous, active-high; clears all state
//   sigRegWrite/writeReg/
//     writeData               write port 1 (priority port)
//   sigRegWrite2/writeReg2/
//     writeData2              write port 2
//   readReg1/readData1        read port A (combinational)
//   readReg2/readData2        read port B (combinational)
//   sigClear                  start a soft-clear sweep (sampled in IDLE only)
//   clearBusy                 high while the sweep is in progress
//   clearDone                 one-cycle pulse when the sweep completes
// -----------------------------------------------------------------------------
module reg_file_bank #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sigRegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              sigRegWrite2,
  input  logic [ADDR_W-1:0] writeReg2,
  input  logic [DATA_W-1:0] writeData2,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              sigClear,
  output logic              clearBusy,
  output logic              clearDone
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SWEEP = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  logic [1:0]                   state;
  logic [ADDR_W-1:0]            index;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         sweeping;

  assign sweeping  = (state == S_SWEEP);
  assign clearBusy = sweeping;
  assign clearDone = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Clear sequencer. index stops at DEPTH-1 and the FSM leaves SWEEP on that
  // terminal count, so the sweep lasts exactly DEPTH cycles.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sigClear) begin
            state <= S_SWEEP;
            index <= '0;
          end
        end
        S_SWEEP: begin
          if (index == ADDR_W'(DEPTH - 1)) state <= S_DONE;
          else                             index <= index + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Per-register priority: port 1, then port 2, then the sweep zero,
  // so an external write to the register being swept this cycle survives.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(i);

    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] q;

      // NOTE: the register file is flop-based and must read back zero right
      // after reset, so every entry sits on the async reset (no RAM macro).
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  q <= '0;
        else if (sigRegWrite  && writeReg  == ADDR) q <= writeData;
        else if (sigRegWrite2 && writeReg2 == ADDR) q <= writeData2;
        else if (sweeping && index == ADDR)         q <= '0;
      end

      assign regs[i] = q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. Bypass forwards external write data only; the sweep zero is
  // never forwarded. A hardwired register 0 reads zero even when bypassed.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1,
    input logic              we2,
    input logic [ADDR_W-1:0] wa2,
    input logic [DATA_W-1:0] wd2
  );
    logic [DATA_W-1:0] data;
    data = stored;
    if (BYPASS != 0) begin
      if (we1 && wa1 == addr)      data = wd1;
      else if (we2 && wa2 == addr) data = wd2;
    end
    if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    return data;
  endfunction

  // NOTE: combinational logic uses blocking assignments with a full default
  // on every path, so no latch can be inferred.
  always_comb begin
    readData1 = read_mux(readReg1, regs[readReg1], sigRegWrite, writeReg, writeData,
                         sigRegWrite2, writeReg2, writeData2);
    readData2 = read_mux(readReg2, regs[readReg2], sigRegWrite, writeReg, writeData,
                         sigRegWrite2, writeReg2, writeData2);
  end

endmodule
